// File: rtl/fifo_pkg.sv
// Shared definitions for the byte-to-word packer feeding the 8 x 32-bit FIFO.
//   WORD_W / BYTE_W / LANES : word geometry (one 32-bit word = 4 byte lanes)
//   pack_state_t            : frame FSM states
//   DEFAULT_PAD_BYTE        : fill value for unused lanes of a flushed word
package fifo_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } pack_state_t;

  localparam logic [BYTE_W-1:0] DEFAULT_PAD_BYTE = 8'h00;
endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words and drives the FIFO write port.
// A frame delimiter flushes a partial word (unused lanes = PAD_BYTE) and
// publishes the frame's word count.
// Ports:
//   pack_clk, pack_rst_n : clock, asynchronous active-low reset
//   byte_valid/byte_data/byte_last : input byte stream, last qualified by valid
//   data_valid/data      : one-cycle word strobe and packed word (0 when idle)
//   pad_bytes            : padded lanes of the strobed word (0 when idle)
//   frame_done           : pulse with the last word of a frame
//   frame_words          : saturating word count of the last completed frame
module byte_word_packer
  import fifo_pkg::*;
#(
  parameter bit                LITTLE_ENDIAN = 1'b1,
  parameter logic [BYTE_W-1:0] PAD_BYTE      = DEFAULT_PAD_BYTE,
  parameter int                FRAME_CNT_W   = 16
) (
  input  logic                   pack_clk,
  input  logic                   pack_rst_n,
  input  logic                   byte_valid,
  input  logic [BYTE_W-1:0]      byte_data,
  input  logic                   byte_last,
  output logic                   data_valid,
  output logic [WORD_W-1:0]      data,
  output logic [1:0]             pad_bytes,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_words
);

  pack_state_t            r_state;
  pack_state_t            w_state_nxt;
  logic [1:0]             r_lane;
  logic [WORD_W-1:0]      r_shift;
  logic [FRAME_CNT_W-1:0] r_cnt;
  logic                   r_data_valid;
  logic [WORD_W-1:0]      r_data;
  logic [1:0]             r_pad;
  logic                   r_frame_done;
  logic [FRAME_CNT_W-1:0] r_frame_words;

  logic [WORD_W-1:0]      w_word;
  logic                   w_emit;

  // Bit offset of a logical lane (lane 0 = first byte of the word).
  function automatic int lane_pos(input int lane);
    return LITTLE_ENDIAN ? BYTE_W * lane : BYTE_W * (LANES - 1 - lane);
  endfunction

  function automatic logic [WORD_W-1:0] lane_insert(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        lane,
                                                    input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] res;
    res = word;
    res[lane_pos(int'(lane)) +: BYTE_W] = b;
    return res;
  endfunction

  // Lanes after the last written one may hold bytes from an earlier word;
  // overwrite them so only accepted bytes and padding leave the block.
  function automatic logic [WORD_W-1:0] pad_fill(input logic [WORD_W-1:0] word,
                                                 input logic [1:0]        last_lane);
    logic [WORD_W-1:0] res;
    res = word;
    for (int i = 0; i < LANES; i++) begin
      if (i > int'(last_lane)) res[lane_pos(i) +: BYTE_W] = PAD_BYTE;
    end
    return res;
  endfunction

  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign w_word = lane_insert(r_shift, r_lane, byte_data);
  assign w_emit = byte_valid && (byte_last || (r_lane == 2'd3));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (byte_valid && !byte_last) w_state_nxt = PACK;
      PACK:    if (byte_valid && byte_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pack_clk or negedge pack_rst_n) begin
    if (!pack_rst_n) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge pack_clk or negedge pack_rst_n) begin
    if (!pack_rst_n) begin
      r_lane        <= '0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_data_valid  <= 1'b0;
      r_data        <= '0;
      r_pad         <= '0;
      r_frame_done  <= 1'b0;
      r_frame_words <= '0;
    end else begin
      r_data_valid <= w_emit;
      r_data       <= w_emit ? pad_fill(w_word, r_lane) : '0;
      r_pad        <= w_emit ? 2'd3 - r_lane : 2'd0;
      r_frame_done <= byte_valid && byte_last;
      if (byte_valid) begin
        r_shift <= w_word;
        r_lane  <= byte_last ? 2'd0 : r_lane + 2'd1;
        if (byte_last) begin
          r_frame_words <= sat_inc(r_cnt);
          r_cnt         <= '0;
        end else if (r_lane == 2'd3) begin
          r_cnt <= sat_inc(r_cnt);
        end
      end
    end
  end

  assign data_valid  = r_data_valid;
  assign data        = r_data;
  assign pad_bytes   = r_pad;
  assign frame_done  = r_frame_done;
  assign frame_words = r_frame_words;

endmodule
